// File: rtl/cla_pipe_add_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-look-ahead adder/subtractor.
//   - default geometry (CLA_DEF_WIDTH / CLA_DEF_SEG)
//   - cla_mode_e      : add / subtract selector encoding on the 'sub' input
//   - cla_stages()    : number of pipeline stages for a WIDTH/SEG pair
//   - cla_params_ok() : geometry legality, checked at elaboration by the top
//   - cla_skew_off()  : bit offset of a stage's upper-operand skew register
//                       inside the flat skew vector
//   - cla_sum_off()   : bit offset of a stage's partial-sum register inside
//                       the flat deskew vector
// No ports (package).
// -----------------------------------------------------------------------------
package cla_pkg;

   localparam int CLA_DEF_WIDTH = 32;
   localparam int CLA_DEF_SEG   = 8;

   typedef enum logic {
      CLA_ADD = 1'b0,
      CLA_SUB = 1'b1
   } cla_mode_e;

   function automatic int cla_stages(input int width, input int seg);
      return (seg >= 1) ? (width / seg) : 1;
   endfunction

   function automatic bit cla_params_ok(input int width, input int seg);
      return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
   endfunction

   // Stage k keeps the operand bits not yet consumed: WIDTH-(k+1)*SEG bits.
   // The offset of stage k is the total of all earlier stages' widths.
   function automatic int cla_skew_off(input int width, input int seg, input int k);
      return k * width - (seg * k * (k + 1)) / 2;
   endfunction

   // Stage k holds the (k+1) finished low segments: (k+1)*SEG bits.
   function automatic int cla_sum_off(input int seg, input int k);
      return (seg * k * (k + 1)) / 2;
   endfunction

endpackage

// File: rtl/cla_pipe_add_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_add_if
// Valid/ready stream bundle for cla_pipe_add.
//   Request side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : the producer/consumer around the adder (drives operands and
//            out_ready, observes in_ready and the result)
//   slave  : the adder itself
// WIDTH must match the WIDTH of the cla_pipe_add it is connected to.
// -----------------------------------------------------------------------------
interface cla_pipe_add_if
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_pipe_add_seg.sv
// -----------------------------------------------------------------------------
// cla_seg
// Purely combinational SEG-bit carry-look-ahead adder. Every carry is formed
// directly from generate/propagate terms and ci, so there is no ripple chain
// inside the segment.
// Ports:
//   a, b  [SEG] : segment operands
//   ci          : carry into bit 0
//   s     [SEG] : segment sum
//   co          : carry out of bit SEG-1
//   c_msb       : carry into bit SEG-1 (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           c_msb
);

   logic [SEG-1:0] w_g;
   logic [SEG-1:0] w_p;
   logic [SEG:0]   w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..1]g[0] | p[i..0]ci
   // Built as an unrolled sum of products; w_pp accumulates the propagate
   // product from bit i downwards so each term is a flat AND.
   always_comb begin : p_lookahead
      logic w_acc;
      logic w_pp;
      w_c    = '0;
      w_acc  = 1'b0;
      w_pp   = 1'b0;
      w_c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         w_acc = w_g[i];
         w_pp  = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_acc = w_acc | (w_g[j] & w_pp);
            w_pp  = w_pp & w_p[j];
         end
         w_c[i+1] = w_acc | (w_pp & ci);
      end
   end

   assign s     = w_p ^ w_c[SEG-1:0];
   assign co    = w_c[SEG];
   assign c_msb = w_c[SEG-1];

endmodule

// File: rtl/cla_pipe_add.sv
// -----------------------------------------------------------------------------
// cla_pipe_add
// Pipelined carry-look-ahead adder/subtractor, one SEG-bit segment per stage,
// STAGES = WIDTH/SEG stages, one result per cycle, valid/ready handshake with
// a single global advance enable.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; drops all valid bits and clears
//           every pipeline register (so sum/cout/ovf read 0)
//   bus   : cla_pipe_add_if.slave
//           in_valid/in_ready/a/b/cin/sub  -> operands (sub=1: a-b, cin ignored)
//           out_valid/out_ready/sum/cout/ovf -> registered result
// Only combinational input-to-output path: out_ready -> in_ready.
// -----------------------------------------------------------------------------
module cla_pipe_add
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_DEF_WIDTH,
   parameter int SEG   = CLA_DEF_SEG
) (
   input  logic           clk,
   input  logic           rst_n,
   cla_pipe_add_if.slave  bus
);

   localparam int STAGES   = cla_stages(WIDTH, SEG);
   localparam int SKEW_W   = cla_skew_off(WIDTH, SEG, STAGES - 1);
   localparam int SKEW_WD  = (SKEW_W > 0) ? SKEW_W : 1;
   localparam int SUM_W    = cla_sum_off(SEG, STAGES);
   localparam int LAST_OFF = cla_sum_off(SEG, STAGES - 1);

   if (!cla_params_ok(WIDTH, SEG)) begin : g_bad_params
      $error("cla_pipe_add: WIDTH must be a positive integer multiple of SEG (SEG >= 1)");
   end

   // Flat vectors collecting every stage's registers; each stage owns a
   // disjoint slice (see cla_skew_off / cla_sum_off).
   logic                 w_adv;
   logic [STAGES-1:0]    r_valid;
   logic [STAGES-1:0]    w_carry;
   logic [SKEW_WD-1:0]   w_a_skew;
   logic [SKEW_WD-1:0]   w_b_skew;
   logic [SUM_W-1:0]     w_sum_pipe;
   logic                 w_ovf;
   logic [WIDTH-1:0]     w_b_eff;
   logic                 w_c0;

   // Subtraction as a + ~b + 1.
   assign w_b_eff = (bus.sub == CLA_SUB) ? ~bus.b : bus.b;
   assign w_c0    = (bus.sub == CLA_SUB) ? 1'b1 : bus.cin;

   // Whole pipeline moves together: it may advance whenever the output slot
   // is empty or being consumed this cycle.
   assign w_adv        = ~r_valid[STAGES-1] | bus.out_ready;
   assign bus.in_ready = w_adv;

   assign bus.out_valid = r_valid[STAGES-1];
   assign bus.sum       = w_sum_pipe[LAST_OFF +: WIDTH];
   assign bus.cout      = w_carry[STAGES-1];
   assign bus.ovf       = w_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (w_adv) begin
         r_valid[0] <= bus.in_valid;
         for (int k = 1; k < STAGES; k++) begin
            r_valid[k] <= r_valid[k-1];
         end
      end
   end

   if (STAGES == 1) begin : g_no_skew
      // A single stage consumes the whole operand at once.
      logic w_unused_skew;
      assign w_a_skew      = '0;
      assign w_b_skew      = '0;
      assign w_unused_skew = ^{w_a_skew, w_b_skew};
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int IN_W    = WIDTH - gi * SEG;      // operand bits arriving
      localparam int OUT_W   = IN_W - SEG;            // operand bits passed on
      localparam int LO_W    = (gi + 1) * SEG;        // finished sum bits
      localparam int SUM_OFF = cla_sum_off(SEG, gi);

      logic [IN_W-1:0] w_a_in;
      logic [IN_W-1:0] w_b_in;
      logic            w_ci;
      logic [SEG-1:0]  w_s;
      logic            w_co;
      logic            w_cmsb;
      logic [LO_W-1:0] r_sum_lo;
      logic            r_co;

      cla_seg #(
         .SEG (SEG)
      ) u_seg (
         .a     (w_a_in[SEG-1:0]),
         .b     (w_b_in[SEG-1:0]),
         .ci    (w_ci),
         .s     (w_s),
         .co    (w_co),
         .c_msb (w_cmsb)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_co <= 1'b0;
         end else if (w_adv) begin
            r_co <= w_co;
         end
      end

      assign w_carry[gi]                   = r_co;
      assign w_sum_pipe[SUM_OFF +: LO_W]   = r_sum_lo;

      if (gi == 0) begin : g_in
         assign w_a_in = bus.a;
         assign w_b_in = w_b_eff;
         assign w_ci   = w_c0;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sum_lo <= '0;
            end else if (w_adv) begin
               r_sum_lo <= w_s;
            end
         end
      end else begin : g_in
         localparam int PREV_SKEW = cla_skew_off(WIDTH, SEG, gi - 1);
         localparam int PREV_SUM  = cla_sum_off(SEG, gi - 1);

         assign w_a_in = w_a_skew[PREV_SKEW +: IN_W];
         assign w_b_in = w_b_skew[PREV_SKEW +: IN_W];
         assign w_ci   = w_carry[gi-1];

         // Deskew: new segment goes on top of the lower segments already done.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sum_lo <= '0;
            end else if (w_adv) begin
               r_sum_lo <= {w_s, w_sum_pipe[PREV_SUM +: gi * SEG]};
            end
         end
      end

      if (OUT_W > 0) begin : g_skew
         localparam int SKEW_OFF = cla_skew_off(WIDTH, SEG, gi);

         logic [OUT_W-1:0] r_a_hi;
         logic [OUT_W-1:0] r_b_hi;
         // Overflow is only meaningful at the top segment.
         logic             w_unused_cmsb;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a_hi <= '0;
               r_b_hi <= '0;
            end else if (w_adv) begin
               r_a_hi <= w_a_in[IN_W-1:SEG];
               r_b_hi <= w_b_in[IN_W-1:SEG];
            end
         end

         assign w_a_skew[SKEW_OFF +: OUT_W] = r_a_hi;
         assign w_b_skew[SKEW_OFF +: OUT_W] = r_b_hi;
         assign w_unused_cmsb               = w_cmsb;
      end else begin : g_last
         logic r_ovf;

         // Signed overflow: carry into MSB differs from carry out of MSB.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf <= 1'b0;
            end else if (w_adv) begin
               r_ovf <= w_cmsb ^ w_co;
            end
         end

         assign w_ovf = r_ovf;
      end
   end

endmodule

// File: tb/tb_cla_pipe_add.sv
module tb_cla_pipe_add;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_checks;

   cla_pipe_add_if #(.WIDTH(32)) bus  ();
   cla_pipe_add_if #(.WIDTH(32)) bus1 ();

   cla_pipe_add #(.WIDTH(32), .SEG(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cla_pipe_add #(.WIDTH(32), .SEG(32)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of run, required $finish before 200000");
      $fatal(1);
   end

   // Reference model: plain 33-bit add, overflow from operand/result signs.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      logic [31:0] be;
      logic [32:0] full;
      logic        ov;
      be   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
      ov   = (a[31] == be[31]) && (full[31] != a[31]);
      return {full[32], ov, full[31:0]};
   endfunction

   function automatic logic [63:0] ex(input logic v, input logic co, input logic ov,
                                      input logic [31:0] s);
      return {29'd0, v, co, ov, s};
   endfunction

   function automatic logic [63:0] obs0();
      return {29'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum};
   endfunction

   function automatic logic [63:0] obs1();
      return {29'd0, bus1.out_valid, bus1.cout, bus1.ovf, bus1.sum};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
   endtask

   task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      bus1.in_valid = 1'b1;
      bus1.a        = a;
      bus1.b        = b;
      bus1.cin      = cin;
      bus1.sub      = sub;
   endtask

   logic [31:0] op_a   [10];
   logic [31:0] op_b   [10];
   logic        op_cin [10];
   logic        op_sub [10];

   initial begin
      int   issued;
      int   idx;
      logic stall;

      n_pass   = 0;
      n_checks = 0;
      rst_n    = 1'b0;
      bus.in_valid   = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0; bus.sub  = 1'b0;
      bus.out_ready  = 1'b1;
      bus1.in_valid  = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
      bus1.out_ready = 1'b1;

      op_a[0] = 32'h0000_0001; op_b[0] = 32'h0000_0002; op_cin[0] = 1'b0; op_sub[0] = 1'b0;
      op_a[1] = 32'hDEAD_BEEF; op_b[1] = 32'h1234_5678; op_cin[1] = 1'b1; op_sub[1] = 1'b0;
      op_a[2] = 32'h0000_00FF; op_b[2] = 32'h0000_0001; op_cin[2] = 1'b0; op_sub[2] = 1'b0;
      op_a[3] = 32'h8000_0000; op_b[3] = 32'h8000_0000; op_cin[3] = 1'b0; op_sub[3] = 1'b0;
      op_a[4] = 32'h0000_0000; op_b[4] = 32'h0000_0001; op_cin[4] = 1'b0; op_sub[4] = 1'b1;
      op_a[5] = 32'hCAFE_F00D; op_b[5] = 32'hCAFE_F00D; op_cin[5] = 1'b0; op_sub[5] = 1'b1;
      op_a[6] = 32'h7FFF_FFFF; op_b[6] = 32'hFFFF_FFFF; op_cin[6] = 1'b0; op_sub[6] = 1'b1;
      op_a[7] = 32'h00FF_FF00; op_b[7] = 32'h0000_0100; op_cin[7] = 1'b1; op_sub[7] = 1'b0;
      op_a[8] = 32'hA5A5_A5A5; op_b[8] = 32'h5A5A_5A5A; op_cin[8] = 1'b1; op_sub[8] = 1'b0;
      op_a[9] = 32'h1357_9BDF; op_b[9] = 32'h2468_ACE0; op_cin[9] = 1'b1; op_sub[9] = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_out",      obs0(), 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_out_seg32", obs1(), 64'd0);
      rst_n = 1'b1;
      tick();

      // Scenario 1: carry through every segment, also on the single-stage DUT
      send (32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      send1(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      tick();
      bus.in_valid  = 1'b0;
      bus1.in_valid = 1'b0;
      chk("s1_seg32_lat1", obs1(), ex(1'b1, 1'b1, 1'b0, 32'h0000_0000));
      tick();
      chk("s1_seg32_bubble", {63'd0, bus1.out_valid}, 64'd0);
      tick();
      chk("s1_not_before_4", {63'd0, bus.out_valid}, 64'd0);
      tick();
      chk("s1_carry_all_segs", obs0(), ex(1'b1, 1'b1, 1'b0, 32'h0000_0000));

      // Scenarios 2-4 issued back to back
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      tick();
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
      tick();
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("s2_add_ovf", obs0(), ex(1'b1, 1'b0, 1'b1, 32'h8000_0000));
      tick();
      chk("s3_sub_borrow", obs0(), ex(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE));
      tick();
      chk("s4_sub_ovf", obs0(), ex(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF));
      tick();

      // Scenario 5: 10 ops streamed, out_ready low on cycles 6..8
      issued = 0;
      for (int cyc = 0; cyc < 18; cyc++) begin
         stall = (cyc >= 6) && (cyc <= 8);
         bus.out_ready = ~stall;
         if (issued < 10) send(op_a[issued], op_b[issued], op_cin[issued], op_sub[issued]);
         else bus.in_valid = 1'b0;
         #1;
         chk($sformatf("bp_in_ready_c%0d", cyc), {63'd0, bus.in_ready}, {63'd0, ~stall});
         if (cyc < 4 || cyc > 16) begin
            chk($sformatf("bp_idle_c%0d", cyc), {63'd0, bus.out_valid}, 64'd0);
         end else begin
            idx = (cyc <= 5) ? (cyc - 4) : ((cyc <= 9) ? 2 : (cyc - 7));
            chk($sformatf("bp_result_c%0d_op%0d", cyc, idx), obs0(),
                {29'd0, 1'b1, model(op_a[idx], op_b[idx], op_cin[idx], op_sub[idx])});
         end
         if (!stall && issued < 10) issued++;
         tick();
      end
      bus.out_ready = 1'b1;

      // Scenario 6: reset with one result showing and three in flight
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      tick();
      send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      tick();
      send(32'h3333_3333, 32'h0000_0001, 1'b0, 1'b1);
      tick();
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("rs_before_reset", obs0(), ex(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF));
      rst_n = 1'b0;
      #1;
      chk("rs_async_clear", obs0(), 64'd0);
      chk("rs_in_ready",    {63'd0, bus.in_ready}, 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rs_no_stale_n0", {63'd0, bus.out_valid}, 64'd0);
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("rs_no_stale_n%0d", k), {63'd0, bus.out_valid}, 64'd0);
         tick();
      end
      chk("rs_first_new", obs0(), ex(1'b1, 1'b0, 1'b0, 32'h2345_6789));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
